// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder backed by a word-organised SRAM: byte/half/word access,
// optional wait states, two-cycle ERROR response for illegal transfers.
module ahb_sram_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);
    // state | meaning
    // IDLE  | no transfer, or zero-wait data phase completing (HREADYOUT=1)
    // WAIT  | wait cycles of a legal transfer (HREADYOUT=0)
    // ERR1  | first ERROR cycle (HREADYOUT=0, HRESP=1)
    // ERR2  | second ERROR cycle (HREADYOUT=1, HRESP=1)
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    localparam int          IDX_W = $clog2(MEM_DEPTH);
    localparam logic [1:0]  WS    = 2'(WAIT_STATES);

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [IDX_W+1:0]        addr_q, addr_d;
    logic                    write_q, write_d;
    logic [2:0]              size_q, size_d;
    logic                    active_q, active_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic                    sample, illegal, commit;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [IDX_W-1:0]        idx_s, idx_q;
    logic [DATA_WIDTH-1:0]   wmask, fwd_word;
    logic                    unused_htrans0;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'b000:  return 4'b0001 << a;
            3'b001:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    assign unused_htrans0 = HTRANS[0];

    assign HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
    assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign HRDATA    = rdata_q;

    assign sample    = HSEL && HREADY && HTRANS[1] && HREADYOUT;
    assign word_addr = {2'b00, HADDR[ADDR_WIDTH-1:2]};
    assign illegal   = (HSIZE > 3'b010)
                    || (HSIZE == 3'b001 && HADDR[0])
                    || (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)
                    || (word_addr >= ADDR_WIDTH'(MEM_DEPTH));
    assign idx_s     = HADDR[IDX_W+1:2];
    assign idx_q     = addr_q[IDX_W+1:2];
    assign commit    = active_q && write_q && (state_q == ST_IDLE);

    always_comb begin
        logic [3:0] m;
        m     = lane_mask(size_q, addr_q[1:0]);
        wmask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    end

    // A zero-wait read sampled while the previous write commits must see that write.
    always_comb begin
        fwd_word = mem_q[idx_s];
        if (commit && idx_q == idx_s)
            fwd_word = (fwd_word & ~wmask) | (HWDATA & wmask);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        size_d   = size_q;
        active_d = active_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
                if (sample) begin
                    addr_d  = HADDR[IDX_W+1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else begin
                        active_d = 1'b1;
                        if (WS != 2'd0) begin
                            state_d = ST_WAIT;
                            cnt_d   = WS;
                        end else if (!HWRITE) begin
                            rdata_d = fwd_word;
                        end
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = ST_IDLE;
                    if (!write_q)
                        rdata_d = mem_q[idx_q];
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            active_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            active_q <= active_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn && commit)
            mem_q[idx_q] <= (mem_q[idx_q] & ~wmask) | (HWDATA & wmask);
    end
endmodule
